// File: rtl/shift_seq_ctrl_if.sv
// Request/response bundle for the shift sequencer.
// The master side issues shift requests and consumes results;
// the slave side is the sequencer itself.
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_op;
  logic [AMT_W-1:0] in_amt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;
  logic             busy;
  logic [7:0]       op_count;

  modport master (
    output in_valid, in_data, in_op, in_amt, out_ready,
    input  in_ready, out_valid, out_data, out_err, busy, op_count
  );

  modport slave (
    input  in_valid, in_data, in_op, in_amt, out_ready,
    output in_ready, out_valid, out_data, out_err, busy, op_count
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: accepts one request at a time, applies one
// 1-bit shift/rotate step per clock for in_amt clocks, then presents the
// result until the consumer takes it. Illegal op codes skip shifting and
// return the operand unchanged with out_err set.
module shift_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input logic            clk,
  input logic            rst_n,
  shift_seq_ctrl_if.slave bus
);

  localparam logic [2:0] OP_LSH  = 3'd0;
  localparam logic [2:0] OP_RSH  = 3'd1;
  localparam logic [2:0] OP_ASH  = 3'd2;
  localparam logic [2:0] OP_ROTL = 3'd3;
  localparam logic [2:0] OP_ROTR = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [2:0]       op_reg, op_next;
  logic [AMT_W-1:0] cnt_reg, cnt_next;
  logic             err_reg, err_next;
  logic [7:0]       op_count_reg, op_count_next;

  // Single 1-bit step of the selected operation; unknown ops leave data alone.
  function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] d,
                                             input logic [2:0]       op);
    case (op)
      OP_LSH:  step1 = {d[WIDTH-2:0], 1'b0};
      OP_RSH:  step1 = {1'b0, d[WIDTH-1:1]};
      OP_ASH:  step1 = {d[WIDTH-1], d[WIDTH-1:1]};
      OP_ROTL: step1 = {d[WIDTH-2:0], d[WIDTH-1]};
      OP_ROTR: step1 = {d[0], d[WIDTH-1:1]};
      default: step1 = d;
    endcase
  endfunction

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      data_reg     <= '0;
      op_reg       <= '0;
      cnt_reg      <= '0;
      err_reg      <= 1'b0;
      op_count_reg <= '0;
    end else begin
      state_reg    <= state_next;
      data_reg     <= data_next;
      op_reg       <= op_next;
      cnt_reg      <= cnt_next;
      err_reg      <= err_next;
      op_count_reg <= op_count_next;
    end
  end

  // Next-state and datapath update: accept in IDLE, step in SHIFT, hold in DONE.
  always_comb begin
    state_next    = state_reg;
    data_next     = data_reg;
    op_next       = op_reg;
    cnt_next      = cnt_reg;
    err_next      = err_reg;
    op_count_next = op_count_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          data_next = bus.in_data;
          op_next   = bus.in_op;
          if (bus.in_op > OP_ROTR) begin
            // Illegal code: report without touching the operand.
            err_next   = 1'b1;
            state_next = DONE;
          end else if (bus.in_amt == '0) begin
            state_next = DONE;
          end else begin
            cnt_next   = bus.in_amt;
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        data_next = step1(data_reg, op_reg);
        cnt_next  = cnt_reg - AMT_W'(1);
        if (cnt_reg == AMT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          err_next      = 1'b0;
          op_count_next = op_count_reg + 8'd1;
          state_next    = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // in_ready is gated by rst_n so nothing looks acceptable while reset is held.
  assign bus.in_ready  = (state_reg == IDLE) && rst_n;
  assign bus.out_valid = (state_reg == DONE);
  assign bus.out_data  = data_reg;
  assign bus.out_err   = err_reg;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.op_count  = op_count_reg;

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width in bits.
REQ-002 The block SHALL have parameter AMT_W, default 3, shift-amount width; maximum amount is 2^AMT_W-1.
REQ-003 Port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit; reset SHALL be asynchronous and active-low.
REQ-005 Port in_valid, input, 1 bit, request present.
REQ-006 Port in_ready, output, 1 bit, block can accept a request.
REQ-007 Port in_data, input, WIDTH bits, operand.
REQ-008 Port in_op, input, 3 bits, operation code: 0 LSH, 1 RSH, 2 ASH, 3 ROTL, 4 ROTR; codes 5-7 are illegal.
REQ-009 Port in_amt, input, AMT_W bits, shift amount.
REQ-010 Port out_valid, output, 1 bit, result present.
REQ-011 Port out_ready, input, 1 bit, consumer accepts the result.
REQ-012 Port out_data, output, WIDTH bits, result.
REQ-013 Port out_err, output, 1 bit, result came from an illegal op code.
REQ-014 Port busy, output, 1 bit, high whenever the FSM is not IDLE.
REQ-015 Port op_count, output, 8 bits, count of completed output handshakes.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; there is no request overlap.
REQ-018 Accept occurs on a rising edge with in_valid=1 and in_ready=1; the block SHALL then latch in_data, in_op and in_amt into internal registers.
REQ-019 On accept with a legal op and in_amt>0, the next state SHALL be SHIFT, with the remaining-count register set to in_amt.
REQ-020 On accept with a legal op and in_amt=0, the next state SHALL be DONE and the data SHALL be left unchanged.
REQ-021 On accept with an illegal op, the next state SHALL be DONE, the data SHALL be left unchanged, and out_err SHALL be set to 1.
REQ-022 Each edge in SHIFT SHALL apply exactly one 1-bit step to the data register and decrement the count.
REQ-023 When the count reaches 0 after a step, the next state SHALL be DONE.
REQ-024 The 1-bit steps SHALL be:
- LSH: {d[W-2:0],0}
- RSH: {0,d[W-1:1]}
- ASH: {d[W-1],d[W-1:1]}
- ROTL: {d[W-2:0],d[W-1]}
- ROTR: {d[0],d[W-1:1]}
REQ-025 out_valid SHALL be 1 only in DONE, first rising amt+1 clock edges after the accept edge (1 edge for amt=0 or an illegal op).
REQ-026 In DONE, out_data and out_err SHALL hold stable until out_ready=1.
REQ-027 On the edge where out_valid and out_ready are both 1, the FSM SHALL go to IDLE, out_err SHALL clear, and op_count SHALL increment.
REQ-028 op_count SHALL wrap from 255 to 0.
REQ-029 in_valid and in_* changes during SHIFT or DONE SHALL be ignored.
REQ-030 out_ready outside DONE SHALL have no effect.
REQ-031 out_data SHALL reflect the internal data register at all times; its value outside DONE is don't-care for consumers.

Reset
REQ-032 While rst_n=0, the block SHALL asynchronously force the following values:
- state IDLE
- count 0
- data register 0, so out_data=0
- out_valid=0
- out_err=0
- busy=0
- op_count=0
REQ-033 While rst_n=0, in_ready SHALL be 0.
REQ-034 After rst_n rises, in_ready SHALL be 1 from the first cycle.
REQ-035 Reset asserted mid-operation (SHIFT or DONE) SHALL discard the operation with no output handshake and no op_count increment.

Verification
REQ-036 LSH: op=0, amt=1, data=8'b11101011 -> out_data=8'b11010110, out_err=0, out_valid 2 edges after accept.
REQ-037 ASH: op=2, amt=3, data=8'b11101011 -> out_data=8'b11111101, out_valid 4 edges after accept; busy=1 throughout.
REQ-038 ROTR: op=4, amt=7, data=8'b11101011 -> out_data=8'b11010111, out_valid 8 edges after accept; RSH with amt=7 on 8'b11111111 -> 8'b00000001.
REQ-039 amt=0 and illegal op:
- op=3, amt=0, data=8'hA5 -> out_data=8'hA5 after 1 edge.
- op=5, amt=6, data=8'h3C -> out_data=8'h3C, out_err=1 after 1 edge; out_err clears after the handshake.
REQ-040 Backpressure: out_ready=0 for 5 cycles in DONE while in_valid=1 with new data -> out_valid, out_data and out_err stable; in_ready=0; the new request is not accepted until after the handshake returns the FSM to IDLE.
REQ-041 Reset and wrap:
- rst_n pulsed low during SHIFT -> all outputs return to reset values immediately; op_count unchanged at 0; the next request completes normally.
- 256 completed operations -> op_count=0.
